muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit holding the HI/LO register pair.
- Sits directly downstream of the register file: consumes the two read-port operands (rs value, rt value) and produces HI/LO for MFHI/MFLO.
- Multi-cycle. Asserts busy so control can stall any later HI/LO access or new mul/div issue.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Only 32 is verified.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  single-cycle request pulse; sampled on a rising edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  operation in progress; new requests ignored
- done  output  1  one-cycle pulse, coincident with the first cycle new HI/LO are visible
- hi  output  WIDTH  HI register (mult upper product / div remainder)
- lo  output  WIDTH  LO register (mult lower product / div quotient)

Behaviour:
- Reset (edge with reset=1): hi=0, lo=0, busy=0, done=0, state=IDLE, internal accumulators cleared.
- Reset has priority over everything, including mid-operation; an aborted operation never raises done.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU: latch a, b and op.
  - Signed ops: record result signs and convert operands to magnitudes. Product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Load iteration counter = WIDTH and go to CALC; busy=1 from the next cycle.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= a at that edge. No busy, no done, stay in IDLE.
- IDLE, start=1, reserved op: ignored.
- CALC multiply: radix-2 shift-add, one bit per cycle, WIDTH cycles, 2*WIDTH-bit accumulator.
- CALC divide: restoring division, one quotient bit per cycle, WIDTH cycles.
- CALC exit: when the counter reaches 0, go to FIX.
- FIX (one cycle):
  - Apply two's-complement negation where the recorded sign is 1 (signed ops only).
  - Write hi/lo and pulse done=1 for exactly one cycle.
  - busy=0 from the same cycle; return to IDLE.
- Latency: start sampled at edge E0; busy=1 after E0 through E32; hi/lo updated, done=1 and busy=0 after E33. Total 33 cycles.
- Divide by zero (b==0, DIV or DIVU): detected at E0, skips CALC, goes straight to FIX. After E1: hi=a (unmodified, signed or unsigned), lo=all-ones, done=1.
- DIV overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0; normal 33-cycle latency.
- start while busy=1 (any op, including MTHI/MTLO): ignored. hi/lo keep their old values until FIX.
- hi/lo hold their previous values during CALC; no partial results are visible.
- start on the same cycle done=1: accepted, since the state is already IDLE.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x64 b=0 -> done after 1 cycle, hi=0x64, lo=0xFFFFFFFF.
- MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, busy stays 0. Then MULTU 3*5, and MTLO a=0xDEAD at cycle 5 of it -> MTLO ignored; final lo=15, hi=0.
- Start DIVU 1000/3, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0; done never asserts. A subsequent MULTU 6*7 gives lo=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding HI/LO: radix-2 shift-add multiply, restoring divide.
// 33-cycle latency (1 cycle for divide-by-zero); requests are ignored while busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div, div_zero, neg_lo, neg_hi;

  // op[2]=0 selects arithmetic; op[1] divide; op[0]=0 signed
  logic             arith, sgn, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign arith  = ~op[2];
  assign sgn    = ~op[0];
  assign b_zero = (b == '0);
  assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   q_res, r_res;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_sh   = {acc, 1'b0};
  assign div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opb};
  assign prod_res = neg_lo ? -acc : acc;
  assign q_res    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_res    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && arith) state_nxt = (op[1] && b_zero) ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && arith) begin
            a_raw    <= a;
            is_div   <= op[1];
            div_zero <= op[1] && b_zero;
            neg_lo   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi   <= sgn && a[WIDTH-1];
            cnt      <= CW'(WIDTH);
            // multiply: acc low holds multiplier; divide: acc low holds dividend
            opb      <= op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          end else if (start && op == 3'b100) begin
            hi <= a;
          end else if (start && op == 3'b101) begin
            lo <= a;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div)
            acc <= div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                                   : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FIX: begin
          done <= 1'b1;
          if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else if (is_div) begin
            hi <= r_res;
            lo <= q_res;
          end else begin
            {hi, lo} <= prod_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand sequences, and random ops vs. an arithmetic model.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // called right after the accepting edge; counts edges until done and busy cycles seen
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = int'(busy);
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (!done) busy_n += int'(busy);
    end
    if (!done) $display("FAIL timeout: done not seen within %0d cycles", lat);
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint      sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    lat = 33;
    eh = '0;
    el = '0;
    case (o)
      3'd0: begin sp = sx * sy; {eh, el} = sp; end
      3'd1: begin up = {32'b0, x} * {32'b0, y}; {eh, el} = up; end
      default: begin
        if (y == 0) begin
          eh = x; el = 32'hFFFF_FFFF; lat = 1;
        end else if (o == 3'd2) begin
          sq = sx / sy; sr = sx % sy;
          el = sq[31:0]; eh = sr[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
    endcase
  endfunction

  initial begin
    int lat, bn, dn;
    logic [31:0] eh, el;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    int mode;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
    vecs[2] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
    vecs[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[6] = '{3'd3, 32'h0000_0064, 32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1};
    vecs[7] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
    vecs[8] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[9] = '{3'd0, 32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0,         33};

    tick(); tick();
    reset = 1'b0;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);

    // MTLO issued mid-multiply must be dropped; HI/LO hold until the result lands
    issue(3'd1, 32'd3, 32'd5);
    repeat (4) tick();
    issue(3'd5, 32'h0000_DEAD, 32'd0);
    chk("hold_lo", lo, 0);
    chk("hold_hi", hi, 32'h1234_5678);
    chk("hold_busy", busy, 1);
    wait_done(lat, bn);
    chk("mtlo_ign_lo", lo, 15);
    chk("mtlo_ign_hi", hi, 0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bn);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy", i), bn, vecs[i].lat);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, eh, el, dn);
      issue(ro, ra, rb);
      wait_done(lat, bn);
      chk($sformatf("rnd%0d_op%0d_hi", i, ro), hi, eh);
      chk($sformatf("rnd%0d_op%0d_lo", i, ro), lo, el);
      chk($sformatf("rnd%0d_lat", i), lat, dn);
    end

    // new request on the done cycle is accepted immediately
    issue(3'd1, 32'd2, 32'd3);
    wait_done(lat, bn);
    chk("b2b_first_lo", lo, 6);
    issue(3'd3, 32'd7, 32'd2);
    wait_done(lat, bn);
    chk("b2b_lat", lat, 33);
    chk("b2b_lo", lo, 3);
    chk("b2b_hi", hi, 1);

    // reset mid-divide aborts without done
    issue(3'd4, 32'h0000_ABCD, 32'd0);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      dn += int'(done);
    end
    chk("abort_no_done", dn, 0);
    issue(3'd1, 32'd6, 32'd7);
    wait_done(lat, bn);
    chk("post_abort_lo", lo, 42);
    chk("post_abort_hi", hi, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
